// File: rtl/jpeg_byte_unstuff.sv
// JPEG entropy-coded-segment unstuffer: drops 0xFF00 stuffing and 0xFF fill bytes,
// strips RSTn/EOI markers and hands clean bytes plus an end-of-image flag to the bit buffer.
module jpeg_byte_unstuff #(
  parameter bit CHECK_RST_SEQ = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       img_start_i,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  input  logic       inport_last_i,
  output logic       inport_accept_o,
  output logic       outport_valid_o,
  output logic [7:0] outport_data_o,
  output logic       outport_last_o,
  input  logic       outport_accept_i,
  output logic       restart_o,
  output logic [2:0] restart_idx_o,
  output logic       marker_err_o
);

  typedef enum logic [2:0] {S_DATA, S_FF, S_RST, S_EOI, S_DONE} state_t;

  state_t     r_state;
  logic       r_p_v;
  logic [7:0] r_p_data;
  logic       r_o_v;
  logic [7:0] r_o_data;
  logic       r_o_last;
  logic       r_o_nodata;
  logic       r_last_sent;
  logic       r_pend_eoi;
  logic [2:0] r_rst_exp;
  logic [2:0] r_restart_idx;
  logic       r_restart;
  logic       r_marker_err;

  logic       w_o_clear;
  logic       w_ofree;
  logic       w_in_xfer;
  logic       w_is_data;
  logic       w_is_rst;
  logic       w_bad;
  logic [7:0] w_data;
  state_t     w_dec_state;

  // A last-only entry carries no data, so it retires without a handshake.
  always_comb begin
    w_o_clear = r_o_v && (r_o_nodata || outport_accept_i);
    w_ofree   = !r_o_v || w_o_clear;
    case (r_state)
      S_DONE:       inport_accept_o = 1'b1;
      S_RST, S_EOI: inport_accept_o = 1'b0;
      default:      inport_accept_o = !r_p_v || w_ofree;
    endcase
    w_in_xfer = inport_valid_i && inport_accept_o;
    w_data    = (r_state == S_FF) ? 8'hFF : inport_data_i;
  end

  always_comb begin
    w_is_data   = 1'b0;
    w_is_rst    = 1'b0;
    w_bad       = 1'b0;
    w_dec_state = r_state;
    case (r_state)
      S_DATA: begin
        if (inport_data_i == 8'hFF) w_dec_state = S_FF;
        else                        w_is_data   = 1'b1;
      end
      S_FF: begin
        if (inport_data_i == 8'h00) begin
          w_is_data   = 1'b1;
          w_dec_state = S_DATA;
        end else if (inport_data_i == 8'hFF) begin
          w_dec_state = S_FF;
        end else if (inport_data_i[7:3] == 5'b11010) begin
          w_is_rst    = 1'b1;
          w_dec_state = S_RST;
        end else if (inport_data_i == 8'hD9) begin
          w_dec_state = S_EOI;
        end else begin
          w_bad       = 1'b1;
          w_dec_state = S_EOI;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      r_state       <= S_DATA;
      r_p_v         <= 1'b0;
      r_p_data      <= 8'h00;
      r_o_v         <= 1'b0;
      r_o_data      <= 8'h00;
      r_o_last      <= 1'b0;
      r_o_nodata    <= 1'b0;
      r_last_sent   <= 1'b0;
      r_pend_eoi    <= 1'b0;
      r_rst_exp     <= 3'd0;
      r_restart_idx <= 3'd0;
      r_restart     <= 1'b0;
      r_marker_err  <= 1'b0;
    end else begin
      r_restart    <= 1'b0;
      r_marker_err <= 1'b0;
      if (w_o_clear) r_o_v <= 1'b0;
      case (r_state)
        S_DATA, S_FF: begin
          if (w_in_xfer) begin
            if (w_is_data) begin
              if (r_p_v) begin
                r_o_v      <= 1'b1;
                r_o_data   <= r_p_data;
                r_o_last   <= 1'b0;
                r_o_nodata <= 1'b0;
              end
              r_p_v    <= 1'b1;
              r_p_data <= w_data;
            end
            if (w_is_rst) begin
              r_restart_idx <= inport_data_i[2:0];
              if (CHECK_RST_SEQ && (inport_data_i[2:0] != r_rst_exp)) r_marker_err <= 1'b1;
              r_rst_exp <= inport_data_i[2:0] + 3'd1;
            end
            if (w_bad) r_marker_err <= 1'b1;
            // End of stream wins over everything except an in-flight restart.
            if (inport_last_i) begin
              if (w_is_rst) begin
                r_state    <= S_RST;
                r_pend_eoi <= 1'b1;
              end else begin
                r_state <= S_EOI;
              end
            end else begin
              r_state <= w_dec_state;
            end
          end
        end
        S_RST: begin
          if (r_p_v && w_ofree) begin
            r_o_v      <= 1'b1;
            r_o_data   <= r_p_data;
            r_o_last   <= 1'b0;
            r_o_nodata <= 1'b0;
            r_p_v      <= 1'b0;
          end
          if (!r_p_v && !r_o_v) begin
            r_restart  <= 1'b1;
            r_pend_eoi <= 1'b0;
            r_state    <= r_pend_eoi ? S_EOI : S_DATA;
          end
        end
        S_EOI: begin
          if (r_p_v && w_ofree) begin
            r_o_v       <= 1'b1;
            r_o_data    <= r_p_data;
            r_o_last    <= 1'b1;
            r_o_nodata  <= 1'b0;
            r_p_v       <= 1'b0;
            r_last_sent <= 1'b1;
          end else if (!r_p_v && !r_last_sent && w_ofree) begin
            r_o_v       <= 1'b1;
            r_o_last    <= 1'b1;
            r_o_nodata  <= 1'b1;
            r_last_sent <= 1'b1;
          end
          if (r_last_sent && !r_o_v) r_state <= S_DONE;
        end
        default: ;
      endcase
    end
  end

  assign outport_valid_o = r_o_v && !r_o_nodata;
  assign outport_data_o  = r_o_data;
  assign outport_last_o  = r_o_v && r_o_last;
  assign restart_o       = r_restart;
  assign restart_idx_o   = r_restart_idx;
  assign marker_err_o    = r_marker_err;

endmodule

// File: tb/tb_jpeg_byte_unstuff.sv
// Directed bench for jpeg_byte_unstuff: expected bytes queued as stimulus is driven,
// matched against bytes captured from the output handshake.
module tb_jpeg_byte_unstuff;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       img_start_i = 1'b0;
  logic       inport_valid_i = 1'b0;
  logic [7:0] inport_data_i = 8'h00;
  logic       inport_last_i = 1'b0;
  logic       inport_accept_o;
  logic       outport_valid_o;
  logic [7:0] outport_data_o;
  logic       outport_last_o;
  logic       outport_accept_i = 1'b1;
  logic       restart_o;
  logic [2:0] restart_idx_o;
  logic       marker_err_o;

  jpeg_byte_unstuff #(.CHECK_RST_SEQ(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .img_start_i(img_start_i),
    .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i),
    .inport_last_i(inport_last_i), .inport_accept_o(inport_accept_o),
    .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
    .outport_last_o(outport_last_o), .outport_accept_i(outport_accept_i),
    .restart_o(restart_o), .restart_idx_o(restart_idx_o), .marker_err_o(marker_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] act_q[$];
  int rs_cnt_q[$];
  int rs_idx_q[$];
  int out_cnt = 0;
  int lastonly_cnt = 0;
  int err_cnt = 0;
  int err_idx = 0;
  int acc_mode = 1;   // 0 stall, 1 always ready, 2 random

  // Downstream ready changes just after each rising edge.
  always @(posedge clk_i) begin
    #1;
    if (acc_mode == 2) outport_accept_i = 1'($urandom_range(0, 1));
    else               outport_accept_i = (acc_mode == 1);
  end

  always @(negedge clk_i) begin
    if (!rst_i && !img_start_i) begin
      if (outport_valid_o && outport_accept_i) begin
        act_q.push_back({outport_last_o, outport_data_o});
        out_cnt++;
      end
      if (outport_last_o && !outport_valid_o) lastonly_cnt++;
      if (restart_o) begin
        rs_cnt_q.push_back(out_cnt);
        rs_idx_q.push_back(int'(restart_idx_o));
      end
      if (marker_err_o) begin
        err_cnt++;
        err_idx = int'(restart_idx_o);
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok = 0;
    inport_valid_i = 1'b1;
    inport_data_i  = d;
    inport_last_i  = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (inport_accept_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send accept timeout", 0, 1);
    @(posedge clk_i);
    #1;
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i], 1'b0);
  endtask

  task automatic expect_bytes(input logic [7:0] s[$]);
    foreach (s[i]) exp_q.push_back({(i == s.size() - 1), s[i]});
  endtask

  // Compare output bytes as they arrive, then allow a few idle cycles for strays.
  task automatic drain(input string tag);
    int idle = 0;
    for (int c = 0; c < 400 && idle < 8; c++) begin
      @(negedge clk_i);
      while (act_q.size() > 0 && exp_q.size() > 0) begin
        logic [8:0] a, e;
        a = act_q.pop_front();
        e = exp_q.pop_front();
        chk({tag, " byte"}, int'(a), int'(e));
      end
      if (exp_q.size() == 0) idle++;
    end
    chk({tag, " missing"}, exp_q.size(), 0);
    chk({tag, " extra"}, act_q.size(), 0);
    exp_q.delete();
    act_q.delete();
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_image();
    @(posedge clk_i);
    #1;
    img_start_i = 1'b1;
    @(posedge clk_i);
    #1;
    img_start_i = 1'b0;
    rs_cnt_q.delete();
    rs_idx_q.delete();
  endtask

  int base_out, base_lo, base_err;
  bit stable;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset valid", outport_valid_o, 0);
    chk("reset last", outport_last_o, 0);
    chk("reset accept", inport_accept_o, 1);
    chk("reset restart", restart_o, 0);
    chk("reset err", marker_err_o, 0);
    chk("reset idx", restart_idx_o, 0);
    @(posedge clk_i);
    #1;

    // Stuffed byte plus EOI.
    base_lo = lastonly_cnt;
    expect_bytes('{8'h12, 8'h34, 8'hFF, 8'h56});
    send_seq('{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56, 8'hFF, 8'hD9});
    drain("seq1");
    chk("seq1 lastonly", lastonly_cnt - base_lo, 0);
    send(8'h55, 1'b0);
    @(negedge clk_i);
    chk("done accept", inport_accept_o, 1);
    drain("done discard");

    // Fill bytes, random downstream ready.
    new_image();
    acc_mode = 2;
    expect_bytes('{8'hAB, 8'hFF, 8'hCD});
    send_seq('{8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hCD, 8'hFF, 8'hD9});
    drain("seq2");
    acc_mode = 1;

    // Two in-order restarts.
    new_image();
    base_out = out_cnt;
    base_err = err_cnt;
    expect_bytes('{8'h11, 8'h22, 8'h33});
    send_seq('{8'h11, 8'hFF, 8'hD0, 8'h22, 8'hFF, 8'hD1, 8'h33, 8'hFF, 8'hD9});
    drain("seq3");
    chk("seq3 restarts", rs_cnt_q.size(), 2);
    if (rs_cnt_q.size() == 2) begin
      chk("seq3 rst0 after", rs_cnt_q[0] - base_out, 1);
      chk("seq3 rst0 idx", rs_idx_q[0], 0);
      chk("seq3 rst1 after", rs_cnt_q[1] - base_out, 2);
      chk("seq3 rst1 idx", rs_idx_q[1], 1);
    end
    chk("seq3 no err", err_cnt - base_err, 0);

    // Out-of-order restart index.
    new_image();
    base_err = err_cnt;
    expect_bytes('{8'hAA, 8'hBB, 8'hCC});
    send_seq('{8'hAA, 8'hFF, 8'hD0, 8'hBB, 8'hFF, 8'hD2, 8'hCC, 8'hFF, 8'hD9});
    drain("seq4");
    chk("seq4 err count", err_cnt - base_err, 1);
    chk("seq4 err idx", err_idx, 2);

    // Unexpected marker.
    new_image();
    base_err = err_cnt;
    expect_bytes('{8'h61});
    send_seq('{8'h61, 8'hFF, 8'hC4});
    drain("badmk");
    chk("badmk err", err_cnt - base_err, 1);

    // Empty image: last-only entry.
    new_image();
    base_out = out_cnt;
    base_lo = lastonly_cnt;
    send_seq('{8'hFF, 8'hD9});
    drain("empty");
    chk("empty valid", out_cnt - base_out, 0);
    chk("empty lastonly", lastonly_cnt - base_lo, 1);

    // Stream ended by inport_last, including a dangling FF.
    new_image();
    expect_bytes('{8'h41, 8'h42});
    send(8'h41, 1'b0);
    send(8'h42, 1'b1);
    drain("inlast");
    new_image();
    expect_bytes('{8'h43});
    send(8'h43, 1'b0);
    send(8'hFF, 1'b1);
    drain("dangling");

    // Downstream stall for 20 cycles.
    new_image();
    acc_mode = 0;
    @(posedge clk_i);
    #1;
    expect_bytes('{8'h01, 8'h02, 8'h03, 8'h04});
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    inport_valid_i = 1'b1;
    inport_data_i  = 8'h03;
    stable = 1;
    repeat (20) begin
      @(negedge clk_i);
      if (inport_accept_o || !outport_valid_o || outport_data_o != 8'h01) stable = 0;
    end
    chk("stall stable", stable, 1);
    acc_mode = 1;
    send(8'h03, 1'b0);
    send_seq('{8'h04, 8'hFF, 8'hD9});
    drain("stall");

    // img_start mid-image drops P/O.
    new_image();
    acc_mode = 0;
    @(posedge clk_i);
    #1;
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    @(negedge clk_i);
    chk("pre-clear valid", outport_valid_o, 1);
    new_image();
    @(negedge clk_i);
    chk("clear valid", outport_valid_o, 0);
    chk("clear last", outport_last_o, 0);
    chk("clear accept", inport_accept_o, 1);
    acc_mode = 1;
    @(posedge clk_i);
    #1;
    expect_bytes('{8'h77});
    send_seq('{8'h77, 8'hFF, 8'hD9});
    drain("after clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
